// File: rtl/conversor_bin_7seg_multidigito_pkg.sv
// Shared constants for the binary-to-7-segment display driver:
// segment patterns, FSM encoding and parameter-derived helper functions.
package conversor_bin_7seg_multidigito_pkg;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;
  localparam logic [6:0] SEG_ZERO    = 7'b1000000;

  localparam logic [1:0] ST_OCIOSO  = 2'd0;
  localparam logic [1:0] ST_DESLOCA = 2'd1;
  localparam logic [1:0] ST_ESCREVE = 2'd2;

  function automatic int largura_contador(input int largura);
    return $clog2(largura + 1);
  endfunction

  // True when 2^largura - 1 can reach 10^digitos, i.e. overflow is possible.
  function automatic bit pode_estourar(input int largura, input int digitos);
    longint limite;
    longint potencia;
    if (largura >= 62) return 1'b1;
    limite   = longint'(1) << largura;
    potencia = 1;
    for (int i = 0; i < digitos; i++) begin
      potencia = potencia * 10;
      if (potencia >= limite) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/conversor_bin_7seg_multidigito_decodificador.sv
// Single BCD digit to active-low 7-segment pattern (gfedcba).
// Codes above 9 cannot occur from double dabble; they decode to blank.
module decodificador_7seg
  import conversor_bin_7seg_multidigito_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_APAGADO;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/conversor_bin_7seg_multidigito.sv
// Sequential binary-to-decimal converter (shift-add-3, one bit per clock)
// driving an active-low multi-digit 7-segment bank with start/busy/done.
module conversor_bin_7seg_multidigito
  import conversor_bin_7seg_multidigito_pkg::*;
#(
  parameter int LARGURA       = 20,
  parameter int DIGITOS       = 6,
  parameter bit SUPRIME_ZEROS = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [LARGURA-1:0]     numero,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   estouro,
  output logic [7*DIGITOS-1:0]   segmentos
);

  localparam int              CW       = largura_contador(LARGURA);
  localparam int              NB       = 4 * DIGITOS;
  localparam bit              ESTOURA  = pode_estourar(LARGURA, DIGITOS);
  localparam logic [CW-1:0]   CONT_FIM = CW'(LARGURA - 1);

  function automatic logic [7*DIGITOS-1:0] padrao_reset();
    logic [7*DIGITOS-1:0] p;
    p = '0;
    for (int k = 0; k < DIGITOS; k++)
      p[7*k +: 7] = (k == 0 || !SUPRIME_ZEROS) ? SEG_ZERO : SEG_APAGADO;
    return p;
  endfunction

  localparam logic [7*DIGITOS-1:0] SEG_RESET = padrao_reset();

  logic [1:0]           estado_q, estado_d;
  logic [LARGURA-1:0]   desloca_q, desloca_d;
  logic [NB-1:0]        bcd_q, bcd_d;
  logic                 acc_q, acc_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic [7*DIGITOS-1:0] seg_q, seg_d;
  logic                 est_q, est_d;
  logic                 pronto_q, pronto_d;

  logic [NB-1:0]        bcd_aj;
  logic                 bit_saida;
  logic [7*DIGITOS-1:0] seg_dec;
  logic [7*DIGITOS-1:0] seg_novo;
  logic                 acima_zero;

  genvar g;
  generate
    for (g = 0; g < DIGITOS; g++) begin : g_dig
      decodificador_7seg u_dec (
        .bcd (bcd_q[4*g +: 4]),
        .seg (seg_dec[7*g +: 7])
      );
    end
  endgenerate

  always_comb begin
    bcd_aj = bcd_q;
    for (int k = 0; k < DIGITOS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_aj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // Walk from the most significant digit down so acima_zero means
  // "this digit and all above it are zero".
  always_comb begin
    seg_novo   = '0;
    acima_zero = 1'b1;
    for (int k = DIGITOS - 1; k >= 0; k--) begin
      acima_zero = acima_zero && (bcd_q[4*k +: 4] == 4'd0);
      if (acc_q)
        seg_novo[7*k +: 7] = SEG_TRACO;
      else if (SUPRIME_ZEROS && k > 0 && acima_zero)
        seg_novo[7*k +: 7] = SEG_APAGADO;
      else
        seg_novo[7*k +: 7] = seg_dec[7*k +: 7];
    end
  end

  always_comb begin
    estado_d  = estado_q;
    desloca_d = desloca_q;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    cont_d    = cont_q;
    seg_d     = seg_q;
    est_d     = est_q;
    pronto_d  = 1'b0;
    bit_saida = 1'b0;
    case (estado_q)
      ST_OCIOSO: begin
        if (iniciar) begin
          desloca_d = numero;
          bcd_d     = '0;
          acc_d     = 1'b0;
          cont_d    = '0;
          estado_d  = ST_DESLOCA;
        end
      end
      ST_DESLOCA: begin
        {bit_saida, bcd_d, desloca_d} = {bcd_aj, desloca_q, 1'b0};
        acc_d  = acc_q | (ESTOURA & bit_saida);
        cont_d = cont_q + CW'(1);
        if (cont_q == CONT_FIM) estado_d = ST_ESCREVE;
      end
      ST_ESCREVE: begin
        seg_d    = seg_novo;
        est_d    = acc_q;
        pronto_d = 1'b1;
        estado_d = ST_OCIOSO;
      end
      default: estado_d = ST_OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= ST_OCIOSO;
      desloca_q <= '0;
      bcd_q     <= '0;
      acc_q     <= 1'b0;
      cont_q    <= '0;
      seg_q     <= SEG_RESET;
      est_q     <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      desloca_q <= desloca_d;
      bcd_q     <= bcd_d;
      acc_q     <= acc_d;
      cont_q    <= cont_d;
      seg_q     <= seg_d;
      est_q     <= est_d;
      pronto_q  <= pronto_d;
    end
  end

  assign ocupado   = (estado_q != ST_OCIOSO);
  assign pronto    = pronto_q;
  assign estouro   = est_q;
  assign segmentos = seg_q;

endmodule
